alu_lane_sched: RTL and testbench
=================================

// Module: alu_lane_sched
// PURPOSE
//  Round-robin scheduler sharing the two lanes of the dual 4-bit ALU (lane1: A0/B0/ALU_Sel1 -> ALU_Out1/CarryOut1,
//  lane2: A1/B1/ALU_Sel2 -> ALU_Out2/CarryOut2) between NUM_REQ requesters (LA-, IO- and WB-side agents).
//  Accepts ops on valid/ready, dispatches each to a free lane, waits ALU_LAT cycles, returns the result to the owner.
//  Sits between the requesters and the ALU instance inside the user project wrapper.
// PARAMETERS
//  NUM_REQ  2  number of requesters (2..8)
//  WIDTH    4  operand/result width; must match the ALU
//  ALU_LAT  1  clock edges from ALU input change to valid registered ALU output (1..7)
// PORTS
//  wb_clk_i      in   1              single clock; everything on posedge
//  wb_rst_ni     in   1              synchronous active-low reset
//  req_valid_i   in   NUM_REQ        op request valid, one bit per requester
//  req_ready_o   out  NUM_REQ        op accepted this cycle (grant)
//  req_a_i       in   NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b_i       in   NUM_REQ*WIDTH  operand B
//  req_op_i      in   NUM_REQ*2      ALU select code, passed through uninterpreted
//  rsp_valid_o   out  NUM_REQ        result available
//  rsp_ready_i   in   NUM_REQ        result consumed
//  rsp_data_o    out  NUM_REQ*WIDTH  ALU result
//  rsp_carry_o   out  NUM_REQ        ALU carry
//  alu_a0_o/alu_b0_o  out  WIDTH     lane1 operands;  alu_sel1_o out 2  lane1 select
//  alu_a1_o/alu_b1_o  out  WIDTH     lane2 operands;  alu_sel2_o out 2  lane2 select
//  alu_out1_i/alu_out2_i  in  WIDTH  lane results;  alu_carry1_i/alu_carry2_i in 1 lane carries
//  lane_busy_o   out  2              bit0 lane1, bit1 lane2 not IDLE
// BEHAVIOUR
//  Reset (wb_rst_ni=0 at posedge): all outputs 0, lanes IDLE, RR pointer 0, outstanding flags clear; in-flight ops dropped.
//  Per-requester outstanding flag: set on grant, cleared on rsp handshake. One op per requester in flight.
//  Eligible(i) = req_valid_i[i] & !outstanding[i]. Free lanes = lanes in IDLE this cycle.
//  Arbitration (combinational): scan eligible from pointer upward with wrap; first hit -> lowest free lane, second -> other.
//  req_ready_o[i]=1 only for granted i; may depend on req_valid_i. Pointer <- (last granted index + 1) mod NUM_REQ; unchanged if no grant.
//  Lane FSM: IDLE -(grant at edge E0)-> EXEC: operands/select/owner registered at E0, held stable on alu_*_o.
//   EXEC counts edges; at edge E0+ALU_LAT+1 captures alu_out/carry into owner's response register, sets rsp_valid_o[owner], -> IDLE.
//   Latency: rsp_valid_o rises ALU_LAT+1 cycles after request handshake. Lane re-grantable in the cycle after capture.
//  alu_*_o hold last dispatched values while IDLE (0 after reset).
//  rsp_valid_o[i] stays high with data/carry stable until rsp_ready_i[i]=1 at a posedge; then cleared.
//  Same-cycle rsp handshake + new request from i: not granted that cycle (outstanding still set); eligible next cycle.
//  rsp_ready_i with rsp_valid_o low: ignored. req_valid_i dropping before grant: no side effect.
//  Result width: data captured verbatim, no extension/truncation; carry captured verbatim.
//  Reset mid-EXEC: op discarded, no response ever issued for it; requester must re-submit.
// TESTING
//  1 Single op: req0 a=4'h9 b=4'h8 op=2'b00, ALU model -> out 4'h1 carry 1 -> ready0 same cycle; alu_a0_o=9, alu_b0_o=8
//    next cycle; rsp_valid_o[0]=1 with data 4'h1 carry 1 two cycles after handshake (ALU_LAT=1).
//  2 Dual grant: req0,req1 valid same cycle, ptr=0 -> req0 lane1, req1 lane2, both ready; ptr wraps to 0; both rsp after 2 cycles.
//  3 NUM_REQ=3, all valid, ptr=0 -> grant 0,1; req2 granted lane1 after lane1 frees; ptr=0 then; RR order 0,1,2 holds over 30 ops.
//  4 Backpressure: rsp_ready_i[0]=0 for 10 cycles -> rsp_data_o/carry stable, req_ready_o[0]=0, requester1 served meanwhile.
//  5 Reset mid-op: wb_rst_ni=0 one cycle during EXEC -> next cycle rsp_valid_o=0, lane_busy_o=0, alu_*_o=0; no stale response.
//  6 ALU_LAT=3: single op -> rsp_valid_o 4 cycles after handshake; lane_busy_o high exactly 4 cycles.

Source files
------------

// File: rtl/alu_lane_sched.sv
// Round-robin scheduler sharing the two lanes of a dual ALU among NUM_REQ requesters.
// Ops are accepted on valid/ready, occupy a lane for ALU_LAT+1 cycles and return to their owner.
module alu_lane_sched #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ*2-1:0]     req_op_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    input  logic [NUM_REQ-1:0]       rsp_ready_i,
    output logic [NUM_REQ*WIDTH-1:0] rsp_data_o,
    output logic [NUM_REQ-1:0]       rsp_carry_o,
    output logic [WIDTH-1:0]         alu_a0_o,
    output logic [WIDTH-1:0]         alu_b0_o,
    output logic [1:0]               alu_sel1_o,
    output logic [WIDTH-1:0]         alu_a1_o,
    output logic [WIDTH-1:0]         alu_b1_o,
    output logic [1:0]               alu_sel2_o,
    input  logic [WIDTH-1:0]         alu_out1_i,
    input  logic [WIDTH-1:0]         alu_out2_i,
    input  logic                     alu_carry1_i,
    input  logic                     alu_carry2_i,
    output logic [1:0]               lane_busy_o
);
    localparam int         PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] LAT_C = 3'(ALU_LAT);

    typedef enum logic {LANE_IDLE = 1'b0, LANE_EXEC = 1'b1} lane_state_t;

    lane_state_t              r_state     [2];
    lane_state_t              w_state_nxt [2];
    logic [2:0]               r_cnt       [2];
    logic [PW-1:0]            r_owner     [2];
    logic [WIDTH-1:0]         r_a         [2];
    logic [WIDTH-1:0]         r_b         [2];
    logic [1:0]               r_sel       [2];
    logic [PW-1:0]            w_disp_idx  [2];
    logic [WIDTH-1:0]         w_lane_out  [2];
    logic [1:0]               w_lane_carry;
    logic [1:0]               w_done;
    logic [1:0]               w_disp;

    logic [PW-1:0]            r_ptr;
    logic [PW-1:0]            w_ptr_nxt;
    logic [NUM_REQ-1:0]       r_outst;
    logic [NUM_REQ-1:0]       w_elig;
    logic [NUM_REQ-1:0]       w_grant;
    logic [NUM_REQ-1:0]       r_rsp_valid;
    logic [NUM_REQ-1:0]       r_rsp_carry;
    logic [NUM_REQ*WIDTH-1:0] r_rsp_data;
    logic [WIDTH-1:0]         w_req_a  [NUM_REQ];
    logic [WIDTH-1:0]         w_req_b  [NUM_REQ];
    logic [1:0]               w_req_op [NUM_REQ];
    int                       w_hits;
    int                       w_idx;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign w_req_a[gi]  = req_a_i[gi*WIDTH +: WIDTH];
        assign w_req_b[gi]  = req_b_i[gi*WIDTH +: WIDTH];
        assign w_req_op[gi] = req_op_i[gi*2 +: 2];
    end

    assign w_lane_out[0]   = alu_out1_i;
    assign w_lane_out[1]   = alu_out2_i;
    assign w_lane_carry    = {alu_carry2_i, alu_carry1_i};
    assign w_elig          = req_valid_i & ~r_outst;

    // Scan from the pointer with wrap: first eligible gets the lowest idle lane, second the other.
    always_comb begin
        w_hits        = 0;
        w_idx         = 0;
        w_grant       = '0;
        w_disp        = '0;
        w_disp_idx[0] = '0;
        w_disp_idx[1] = '0;
        w_ptr_nxt     = r_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (w_elig[PW'(w_idx)]) begin
                if (w_hits == 0 && (r_state[0] == LANE_IDLE || r_state[1] == LANE_IDLE)) begin
                    w_grant[PW'(w_idx)] = 1'b1;
                    w_ptr_nxt           = (w_idx == NUM_REQ - 1) ? '0 : PW'(w_idx + 1);
                    w_hits              = 1;
                    if (r_state[0] == LANE_IDLE) begin
                        w_disp[0]     = 1'b1;
                        w_disp_idx[0] = PW'(w_idx);
                    end else begin
                        w_disp[1]     = 1'b1;
                        w_disp_idx[1] = PW'(w_idx);
                    end
                end else if (w_hits == 1 && r_state[0] == LANE_IDLE && r_state[1] == LANE_IDLE) begin
                    w_grant[PW'(w_idx)] = 1'b1;
                    w_ptr_nxt           = (w_idx == NUM_REQ - 1) ? '0 : PW'(w_idx + 1);
                    w_hits              = 2;
                    w_disp[1]           = 1'b1;
                    w_disp_idx[1]       = PW'(w_idx);
                end
            end
        end
    end

    always_comb begin
        w_done = '0;
        for (int l = 0; l < 2; l++) begin
            w_state_nxt[l] = r_state[l];
            case (r_state[l])
                LANE_IDLE: if (w_disp[l]) w_state_nxt[l] = LANE_EXEC;
                LANE_EXEC: begin
                    if (r_cnt[l] == LAT_C) begin
                        w_done[l]      = 1'b1;
                        w_state_nxt[l] = LANE_IDLE;
                    end
                end
                default: w_state_nxt[l] = LANE_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_ptr       <= '0;
            r_outst     <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_carry <= '0;
            for (int l = 0; l < 2; l++) begin
                r_state[l] <= LANE_IDLE;
                r_cnt[l]   <= '0;
                r_owner[l] <= '0;
                r_a[l]     <= '0;
                r_b[l]     <= '0;
                r_sel[l]   <= '0;
            end
        end else begin
            r_ptr <= w_ptr_nxt;
            for (int l = 0; l < 2; l++) begin
                r_state[l] <= w_state_nxt[l];
                if (w_disp[l]) begin
                    r_cnt[l]   <= '0;
                    r_owner[l] <= w_disp_idx[l];
                    r_a[l]     <= w_req_a[w_disp_idx[l]];
                    r_b[l]     <= w_req_b[w_disp_idx[l]];
                    r_sel[l]   <= w_req_op[w_disp_idx[l]];
                end else if (r_state[l] == LANE_EXEC) begin
                    r_cnt[l] <= r_cnt[l] + 3'd1;
                end
            end
            // A captured result never lands on a requester whose previous response is still pending.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_rsp_valid[i] && rsp_ready_i[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                    r_outst[i]     <= 1'b0;
                end
                if (w_grant[i]) r_outst[i] <= 1'b1;
                for (int l = 0; l < 2; l++) begin
                    if (w_done[l] && r_owner[l] == PW'(i)) begin
                        r_rsp_valid[i]               <= 1'b1;
                        r_rsp_data[i*WIDTH +: WIDTH] <= w_lane_out[l];
                        r_rsp_carry[i]               <= w_lane_carry[l];
                    end
                end
            end
        end
    end

    assign req_ready_o    = w_grant;
    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_data_o     = r_rsp_data;
    assign rsp_carry_o    = r_rsp_carry;
    assign alu_a0_o       = r_a[0];
    assign alu_b0_o       = r_b[0];
    assign alu_sel1_o     = r_sel[0];
    assign alu_a1_o       = r_a[1];
    assign alu_b1_o       = r_b[1];
    assign alu_sel2_o     = r_sel[1];
    assign lane_busy_o[0] = (r_state[0] == LANE_EXEC);
    assign lane_busy_o[1] = (r_state[1] == LANE_EXEC);

endmodule

// File: tb/tb_alu_lane_sched.sv
// Bench for alu_lane_sched: directed scenarios and random traffic against a pipelined ALU model,
// with per-requester expected-result queues drained by an independent response monitor.
`timescale 1ns/1ps
module tb_alu_lane_sched;
    localparam int NR  = 3;
    localparam int W   = 4;
    localparam int LAT = 1;

    logic              wb_clk_i;
    logic              wb_rst_ni;
    logic [NR-1:0]     req_valid_i;
    logic [NR-1:0]     req_ready_o;
    logic [NR*W-1:0]   req_a_i;
    logic [NR*W-1:0]   req_b_i;
    logic [NR*2-1:0]   req_op_i;
    logic [NR-1:0]     rsp_valid_o;
    logic [NR-1:0]     rsp_ready_i;
    logic [NR*W-1:0]   rsp_data_o;
    logic [NR-1:0]     rsp_carry_o;
    logic [W-1:0]      alu_a0_o, alu_b0_o, alu_a1_o, alu_b1_o;
    logic [1:0]        alu_sel1_o, alu_sel2_o;
    logic [W-1:0]      alu_out1_i, alu_out2_i;
    logic              alu_carry1_i, alu_carry2_i;
    logic [1:0]        lane_busy_o;

    alu_lane_sched #(.NUM_REQ(NR), .WIDTH(W), .ALU_LAT(LAT)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_op_i(req_op_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_carry_o(rsp_carry_o),
        .alu_a0_o(alu_a0_o), .alu_b0_o(alu_b0_o), .alu_sel1_o(alu_sel1_o),
        .alu_a1_o(alu_a1_o), .alu_b1_o(alu_b1_o), .alu_sel2_o(alu_sel2_o),
        .alu_out1_i(alu_out1_i), .alu_out2_i(alu_out2_i),
        .alu_carry1_i(alu_carry1_i), .alu_carry2_i(alu_carry2_i),
        .lane_busy_o(lane_busy_o)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    // ALU behaviour: {carry, out}; 00 add, 01 subtract (borrow), 10 and, 11 xor.
    function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        case (op)
            2'b00:   alu_ref = {1'b0, a} + {1'b0, b};
            2'b01:   alu_ref = {1'b0, a} - {1'b0, b};
            2'b10:   alu_ref = {1'b0, a & b};
            default: alu_ref = {1'b0, a ^ b};
        endcase
    endfunction

    logic [W:0] pipe1 [LAT];
    logic [W:0] pipe2 [LAT];
    always_ff @(posedge wb_clk_i) begin
        pipe1[0] <= alu_ref(alu_a0_o, alu_b0_o, alu_sel1_o);
        pipe2[0] <= alu_ref(alu_a1_o, alu_b1_o, alu_sel2_o);
        for (int k = 1; k < LAT; k++) begin
            pipe1[k] <= pipe1[k-1];
            pipe2[k] <= pipe2[k-1];
        end
    end
    assign alu_out1_i   = pipe1[LAT-1][W-1:0];
    assign alu_carry1_i = pipe1[LAT-1][W];
    assign alu_out2_i   = pipe2[LAT-1][W-1:0];
    assign alu_carry2_i = pipe2[LAT-1][W];

    int cyc = 0;
    always_ff @(posedge wb_clk_i) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    task automatic check_eq(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic         carry;
        int           due;
    } exp_t;

    exp_t          sb [NR][$];
    exp_t          mon_e;
    logic [W:0]    mon_r;
    logic [NR-1:0] mon_hs;
    logic [NR-1:0] mon_rem;
    logic [NR-1:0] last_hs = '0;
    logic [NR-1:0] prev_v  = '0;
    bit            rr_mode = 1'b0;
    int            rr_exp  = 0;
    int            rr_cnt  = 0;
    int            g1_cnt  = 0;

    // Monitor: records accepted ops with their due cycle and checks every presented response.
    initial begin
        forever begin
            @(negedge wb_clk_i);
            if (!wb_rst_ni) begin
                for (int i = 0; i < NR; i++) sb[i].delete();
                prev_v  = '0;
                last_hs = '0;
            end else begin
                mon_hs = req_valid_i & req_ready_o;
                check_eq("ready_without_valid", int'(req_ready_o & ~req_valid_i), 0);
                for (int i = 0; i < NR; i++) begin
                    if (mon_hs[i]) begin
                        check_eq("grant_while_outstanding", sb[i].size(), 0);
                        mon_r       = alu_ref(req_a_i[i*W +: W], req_b_i[i*W +: W], req_op_i[i*2 +: 2]);
                        mon_e.data  = mon_r[W-1:0];
                        mon_e.carry = mon_r[W];
                        mon_e.due   = cyc + LAT + 2;
                        sb[i].push_back(mon_e);
                        if (i == 1) g1_cnt++;
                    end
                end
                if (rr_mode && mon_hs != '0) begin
                    mon_rem = mon_hs;
                    for (int k = 0; k < 2; k++) begin
                        if (mon_rem[rr_exp]) begin
                            mon_rem[rr_exp] = 1'b0;
                            rr_exp = (rr_exp + 1) % NR;
                            rr_cnt++;
                        end
                    end
                    check_eq("rr_order", int'(mon_rem), 0);
                end
                for (int i = 0; i < NR; i++) begin
                    if (rsp_valid_o[i]) begin
                        if (sb[i].size() == 0) begin
                            check_eq("unexpected_rsp", int'(rsp_valid_o[i]), 0);
                        end else begin
                            mon_e = sb[i][0];
                            if (!prev_v[i]) check_eq("rsp_latency", cyc, mon_e.due);
                            check_eq("rsp_data", int'(rsp_data_o[i*W +: W]), int'(mon_e.data));
                            check_eq("rsp_carry", int'(rsp_carry_o[i]), int'(mon_e.carry));
                            if (rsp_ready_i[i]) void'(sb[i].pop_front());
                        end
                    end else if (sb[i].size() > 0 && cyc >= sb[i][0].due) begin
                        check_eq("rsp_missing", int'(rsp_valid_o[i]), 1);
                        void'(sb[i].pop_front());
                    end
                end
                prev_v  = rsp_valid_o;
                last_hs = mon_hs;
            end
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic new_op(input int i);
        req_a_i[i*W +: W]  = W'($urandom);
        req_b_i[i*W +: W]  = W'($urandom);
        req_op_i[i*2 +: 2] = 2'($urandom);
    endtask

    task automatic do_reset();
        wb_rst_ni   = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = '0;
        tick();
        wb_rst_ni   = 1'b1;
    endtask

    task automatic renew_granted();
        for (int i = 0; i < NR; i++) if (last_hs[i]) new_op(i);
    endtask

    initial begin
        int g1_start;
        wb_rst_ni   = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        req_op_i    = '0;
        tick();
        do_reset();
        check_eq("rst_rsp_valid", int'(rsp_valid_o), 0);
        check_eq("rst_lane_busy", int'(lane_busy_o), 0);
        check_eq("rst_req_ready", int'(req_ready_o), 0);
        check_eq("rst_rsp_data", int'(rsp_data_o), 0);
        check_eq("rst_alu_ops", int'({alu_a0_o, alu_b0_o, alu_sel1_o, alu_a1_o, alu_b1_o, alu_sel2_o}), 0);

        // Single op: 9 + 8 -> 1 with carry.
        rsp_ready_i      = '1;
        req_a_i[3:0]     = 4'h9;
        req_b_i[3:0]     = 4'h8;
        req_op_i[1:0]    = 2'b00;
        req_valid_i      = 3'b001;
        #1;
        check_eq("t1_ready", int'(req_ready_o), 1);
        tick();
        req_valid_i = '0;
        check_eq("t1_alu_a0", int'(alu_a0_o), 9);
        check_eq("t1_alu_b0", int'(alu_b0_o), 8);
        check_eq("t1_alu_sel1", int'(alu_sel1_o), 0);
        check_eq("t1_lane_busy", int'(lane_busy_o), 1);
        tick();
        tick();
        check_eq("t1_rsp_valid", int'(rsp_valid_o), 1);
        check_eq("t1_rsp_data", int'(rsp_data_o[3:0]), 1);
        check_eq("t1_rsp_carry", int'(rsp_carry_o[0]), 1);
        repeat (3) tick();

        // Dual grant from pointer 0.
        do_reset();
        rsp_ready_i = '1;
        new_op(0);
        new_op(1);
        req_valid_i = 3'b011;
        #1;
        check_eq("t2_ready", int'(req_ready_o), 3);
        tick();
        req_valid_i = '0;
        check_eq("t2_lane_busy", int'(lane_busy_o), 3);
        check_eq("t2_alu_a0", int'(alu_a0_o), int'(req_a_i[3:0]));
        check_eq("t2_alu_a1", int'(alu_a1_o), int'(req_a_i[7:4]));
        check_eq("t2_alu_sel2", int'(alu_sel2_o), int'(req_op_i[3:2]));
        repeat (5) tick();

        // Round-robin order with all requesters continuously valid.
        do_reset();
        rsp_ready_i = '1;
        for (int i = 0; i < NR; i++) new_op(i);
        rr_exp      = 0;
        rr_cnt      = 0;
        rr_mode     = 1'b1;
        req_valid_i = '1;
        for (int c = 0; c < 400 && rr_cnt < 30; c++) begin
            tick();
            renew_granted();
        end
        rr_mode     = 1'b0;
        req_valid_i = '0;
        check_eq("rr_ops_done", int'(rr_cnt >= 30), 1);
        repeat (6) tick();

        // Backpressure on requester 0 while requester 1 keeps being served.
        do_reset();
        rsp_ready_i = 3'b110;
        new_op(0);
        new_op(1);
        req_valid_i = 3'b011;
        tick();
        renew_granted();
        repeat (3) begin
            tick();
            renew_granted();
        end
        g1_start = g1_cnt;
        for (int c = 0; c < 10; c++) begin
            check_eq("bp_ready0_low", int'(req_ready_o[0]), 0);
            check_eq("bp_rsp_valid0", int'(rsp_valid_o[0]), 1);
            tick();
            renew_granted();
        end
        check_eq("bp_req1_served", int'(g1_cnt - g1_start >= 2), 1);
        req_valid_i = '0;
        rsp_ready_i = '1;
        repeat (6) tick();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            req_valid_i = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                new_op(i);
                rsp_ready_i[i] = ($urandom_range(3) != 0);
            end
            tick();
        end
        req_valid_i = '0;
        rsp_ready_i = '1;
        repeat (8) tick();
        for (int i = 0; i < NR; i++) check_eq("sb_drained", sb[i].size(), 0);

        // Reset while an op is executing: it must vanish.
        new_op(0);
        req_valid_i = 3'b001;
        tick();
        req_valid_i = '0;
        check_eq("t5_busy_before", int'(lane_busy_o), 1);
        tick();
        wb_rst_ni = 1'b0;
        tick();
        wb_rst_ni = 1'b1;
        check_eq("t5_rsp_valid", int'(rsp_valid_o), 0);
        check_eq("t5_lane_busy", int'(lane_busy_o), 0);
        check_eq("t5_alu_ops", int'({alu_a0_o, alu_b0_o, alu_sel1_o, alu_a1_o, alu_b1_o, alu_sel2_o}), 0);
        for (int c = 0; c < 8; c++) begin
            tick();
            check_eq("t5_no_stale", int'(rsp_valid_o), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

endmodule
